// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the core load/store
// unit and the host port, with a host-exclusive hold and tag-routed read returns.
module dram_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              power_ON,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,

    input  logic              hold_core,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        LAST_CORE = 1'b0,
        LAST_HOST = 1'b1
    } last_grant_e;

    last_grant_e last_grant, last_grant_next;

    logic core_elig;
    logic host_elig;
    logic core_win;
    logic host_win;

    // Read tags: valid bit plus requester id (1 = host), one stage per cycle of RAM latency.
    logic [RD_LAT-1:0] tag_valid;
    logic [RD_LAT-1:0] tag_host;
    logic              launch_valid;
    logic              launch_host;

    always_ff @(posedge clk or negedge power_ON) begin
        if (!power_ON) begin
            last_grant <= LAST_HOST;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        core_elig       = core_req & ~hold_core;
        host_elig       = host_req;
        core_win        = 1'b0;
        host_win        = 1'b0;
        last_grant_next = last_grant;

        // A tie goes to whichever requester did not win last.
        if (power_ON) begin
            if (core_elig && (!host_elig || last_grant == LAST_HOST)) begin
                core_win = 1'b1;
            end else if (host_elig) begin
                host_win = 1'b1;
            end
        end

        if (core_win) begin
            last_grant_next = LAST_CORE;
        end else if (host_win) begin
            last_grant_next = LAST_HOST;
        end
    end

    assign core_gnt = core_win;
    assign host_gnt = host_win;

    assign launch_valid = (core_win & ~core_we) | (host_win & ~host_we);
    assign launch_host  = host_win;

    always_ff @(posedge clk or negedge power_ON) begin
        if (!power_ON) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= core_win | host_win;
            if (core_win) begin
                mem_we    <= core_we;
                mem_addr  <= core_addr;
                mem_wdata <= core_wdata;
            end else if (host_win) begin
                mem_we    <= host_we;
                mem_addr  <= host_addr;
                mem_wdata <= host_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge power_ON) begin
        if (!power_ON) begin
            tag_valid   <= '0;
            tag_host    <= '0;
            core_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            tag_valid   <= (tag_valid << 1) | RD_LAT'(launch_valid);
            tag_host    <= (tag_host << 1) | RD_LAT'(launch_host);
            core_rvalid <= tag_valid[RD_LAT-1] & ~tag_host[RD_LAT-1];
            host_rvalid <= tag_valid[RD_LAT-1] & tag_host[RD_LAT-1];
        end
    end

    assign core_rdata = mem_rdata;
    assign host_rdata = mem_rdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized scoreboard bench for dram_arbiter: two instances (RD_LAT 1 and 3)
// share stimulus; each has its own RAM model and reference arbiter model.
module tb_dram_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          power_ON;
    logic          core_req, core_we, host_req, host_we, hold_core;
    logic [AW-1:0] core_addr, host_addr;
    logic [DW-1:0] core_wdata, host_wdata;

    logic          core_gnt[2], core_rvalid[2], host_gnt[2], host_rvalid[2];
    logic          mem_en[2], mem_we[2];
    logic [DW-1:0] core_rdata[2], host_rdata[2], mem_wdata[2], mem_rdata[2];
    logic [AW-1:0] mem_addr[2];

    int passed = 0;
    int total  = 0;
    int pending[2];

    function automatic logic [7:0] init_val(logic [AW-1:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_lat
        localparam int LAT = (k == 0) ? 1 : 3;

        dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
            .clk        (clk),
            .power_ON   (power_ON),
            .core_req   (core_req),
            .core_we    (core_we),
            .core_addr  (core_addr),
            .core_wdata (core_wdata),
            .core_gnt   (core_gnt[k]),
            .core_rvalid(core_rvalid[k]),
            .core_rdata (core_rdata[k]),
            .host_req   (host_req),
            .host_we    (host_we),
            .host_addr  (host_addr),
            .host_wdata (host_wdata),
            .host_gnt   (host_gnt[k]),
            .host_rvalid(host_rvalid[k]),
            .host_rdata (host_rdata[k]),
            .hold_core  (hold_core),
            .mem_en     (mem_en[k]),
            .mem_we     (mem_we[k]),
            .mem_addr   (mem_addr[k]),
            .mem_wdata  (mem_wdata[k]),
            .mem_rdata  (mem_rdata[k])
        );

        // RAM model: read data appears LAT cycles after the cycle mem_en is sampled.
        logic [7:0] ram [logic [AW-1:0]];
        logic [7:0] rpipe [LAT];
        assign mem_rdata[k] = rpipe[LAT-1];

        initial begin
            for (int i = 0; i < LAT; i++) rpipe[i] = 8'h00;
            forever begin
                @(posedge clk);
                for (int i = LAT - 1; i > 0; i--) rpipe[i] = rpipe[i-1];
                rpipe[0] = 8'hEE;
                if (mem_en[k] === 1'b1) begin
                    if (mem_we[k]) ram[mem_addr[k]] = mem_wdata[k];
                    else rpipe[0] = ram.exists(mem_addr[k]) ? ram[mem_addr[k]] : init_val(mem_addr[k]);
                end
            end
        end

        // Reference model and monitor.
        exp_t          cq[$], hq[$];
        exp_t          e;
        logic [7:0]    mm [logic [AW-1:0]];
        bit            last_host, xen, xwe, ce, he, pc, ph;
        logic [AW-1:0] xaddr;
        logic [7:0]    xwd;
        int            cyc;
        string         p;

        initial begin
            last_host = 1'b1; xen = 1'b0; xwe = 1'b0; xaddr = '0; xwd = '0; cyc = 0;
            p = $sformatf("L%0d ", LAT);
            pending[k] = 0;
            forever begin
                @(negedge clk);
                if (!power_ON) begin
                    cq.delete(); hq.delete();
                    last_host = 1'b1; xen = 1'b0; xwe = 1'b0; xaddr = '0; xwd = '0;
                    check({p, "reset core_gnt"}, 32'(core_gnt[k]), 32'(0));
                    check({p, "reset host_gnt"}, 32'(host_gnt[k]), 32'(0));
                    check({p, "reset mem_en"}, 32'(mem_en[k]), 32'(0));
                    check({p, "reset rvalid"}, 32'({core_rvalid[k], host_rvalid[k]}), 32'(0));
                end else begin
                    check({p, "mem_en"}, 32'(mem_en[k]), 32'(xen));
                    check({p, "mem_we"}, 32'(mem_we[k]), 32'(xwe));
                    check({p, "mem_addr"}, 32'(mem_addr[k]), 32'(xaddr));
                    check({p, "mem_wdata"}, 32'(mem_wdata[k]), 32'(xwd));

                    if (core_rvalid[k]) begin
                        if (cq.size() == 0) check({p, "core_rvalid spurious"}, 32'(1), 32'(0));
                        else begin
                            e = cq.pop_front();
                            check({p, "core_rvalid cycle"}, 32'(cyc), 32'(e.due));
                            check({p, "core_rdata"}, 32'(core_rdata[k]), 32'(e.data));
                        end
                    end else if (cq.size() > 0 && cq[0].due <= cyc) begin
                        e = cq.pop_front();
                        check({p, "core_rvalid missing"}, 32'(0), 32'(1));
                    end

                    if (host_rvalid[k]) begin
                        if (hq.size() == 0) check({p, "host_rvalid spurious"}, 32'(1), 32'(0));
                        else begin
                            e = hq.pop_front();
                            check({p, "host_rvalid cycle"}, 32'(cyc), 32'(e.due));
                            check({p, "host_rdata"}, 32'(host_rdata[k]), 32'(e.data));
                        end
                    end else if (hq.size() > 0 && hq[0].due <= cyc) begin
                        e = hq.pop_front();
                        check({p, "host_rvalid missing"}, 32'(0), 32'(1));
                    end

                    ce = core_req & ~hold_core;
                    he = host_req;
                    pc = ce && (!he || last_host);
                    ph = he && !pc;
                    check({p, "core_gnt"}, 32'(core_gnt[k]), 32'(pc));
                    check({p, "host_gnt"}, 32'(host_gnt[k]), 32'(ph));

                    xen = pc | ph;
                    if (pc) begin
                        xwe = core_we; xaddr = core_addr; xwd = core_wdata; last_host = 1'b0;
                        if (core_we) mm[core_addr] = core_wdata;
                        else begin
                            e.due  = cyc + 1 + LAT;
                            e.data = mm.exists(core_addr) ? mm[core_addr] : init_val(core_addr);
                            cq.push_back(e);
                        end
                    end else if (ph) begin
                        xwe = host_we; xaddr = host_addr; xwd = host_wdata; last_host = 1'b1;
                        if (host_we) mm[host_addr] = host_wdata;
                        else begin
                            e.due  = cyc + 1 + LAT;
                            e.data = mm.exists(host_addr) ? mm[host_addr] : init_val(host_addr);
                            hq.push_back(e);
                        end
                    end
                end
                pending[k] = cq.size() + hq.size();
                cyc++;
            end
        end
    end

    // Request tasks: called just after a rising edge, return just after the edge ending the grant cycle.
    task automatic core_issue(bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (core_gnt[0]) begin
                @(posedge clk); #1;
                core_req = 1'b0;
                return;
            end
        end
        total++;
        $display("FAIL core_gnt timeout: got no grant expected grant within 300 cycles");
        core_req = 1'b0;
    endtask

    task automatic host_issue(bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (host_gnt[0]) begin
                @(posedge clk); #1;
                host_req = 1'b0;
                return;
            end
        end
        total++;
        $display("FAIL host_gnt timeout: got no grant expected grant within 300 cycles");
        host_req = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        power_ON = 1'b0; hold_core = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) @(posedge clk);
        #1 power_ON = 1'b1;
        idle(1);

        core_issue(1'b1, 19'h00005, 8'hA5);
        idle(3);

        fork
            for (int i = 0; i < 8; i++) core_issue(1'b0, AW'(i), 8'h00);
            for (int i = 0; i < 8; i++) host_issue(1'b0, AW'($urandom_range(0, 255)), 8'h00);
        join
        idle(5);

        hold_core = 1'b1;
        fork
            core_issue(1'b0, 19'h00003, 8'h00);
            begin
                for (int i = 0; i <= 10; i++) host_issue(1'b0, AW'(i), 8'h00);
                hold_core = 1'b0;
            end
        join
        idle(5);

        fork
            core_issue(1'b0, 19'd100, 8'h00);
            host_issue(1'b0, 19'd200, 8'h00);
        join
        idle(6);

        host_issue(1'b0, AW'($urandom_range(0, 63)), 8'h00);
        power_ON = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset immediate mem_en", 32'(mem_en[k]), 32'(0));
            check("reset immediate rvalid", 32'({core_rvalid[k], host_rvalid[k]}), 32'(0));
        end
        idle(2);
        power_ON = 1'b1;
        idle(6);
        fork
            core_issue(1'b0, 19'h00011, 8'h00);
            host_issue(1'b0, 19'h00022, 8'h00);
        join
        idle(5);

        core_issue(1'b1, 19'h7FFFF, 8'h5A);
        core_issue(1'b0, 19'h7FFFF, 8'h00);
        idle(6);

        fork
            for (int i = 0; i < 60; i++) begin
                idle($urandom_range(0, 1));
                core_issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 8'($urandom));
            end
            for (int i = 0; i < 60; i++) begin
                idle($urandom_range(0, 1));
                host_issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 8'($urandom));
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    @(posedge clk); #1;
                    hold_core = ($urandom_range(0, 3) == 0);
                end
                hold_core = 1'b0;
            end
        join
        idle(10);

        check("drain L1 pending", 32'(pending[0]), 32'(0));
        check("drain L3 pending", 32'(pending[1]), 32'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
